// File: rtl/brew_sequencer.sv
// rtl/brew_sequencer.sv - one beverage cycle: preheat then per-recipe valve stages
module brew_sequencer #(
    parameter int TICK_CYC   = 50_000_000,
    parameter int HEAT_TICKS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] c_type,
    input  logic       start,
    input  logic       cancel,
    output logic       heater,
    output logic       v_coffee,
    output logic       v_water,
    output logic       v_milk,
    output logic       v_choc,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic       err
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] HEAT   = 3'd1;
    localparam logic [2:0] COFFEE = 3'd2;
    localparam logic [2:0] WATER  = 3'd3;
    localparam logic [2:0] MILK   = 3'd4;
    localparam logic [2:0] CHOC   = 3'd5;
    localparam logic [2:0] DONE   = 3'd6;

    localparam logic [2:0] BEV_ESPRESSO  = 3'd1;
    localparam logic [2:0] BEV_AMERICANO = 3'd2;
    localparam logic [2:0] BEV_LATTE     = 3'd3;
    localparam logic [2:0] BEV_MOCHA     = 3'd4;

    localparam int            PW         = $clog2(TICK_CYC);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYC - 1);
    localparam logic [3:0]    HEAT_LEN   = 4'(HEAT_TICKS);

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [2:0]    bev_q;
    logic [2:0]    bev_nxt;
    logic [PW-1:0] presc;
    logic [3:0]    tick;
    logic [3:0]    cur_ticks;
    logic          stage_end;
    logic          stage_active;
    logic          bev_valid;
    logic          abort_now;
    logic          err_now;

    // Recipe table: length of a stage in ticks for the latched beverage.
    function automatic logic [3:0] stage_ticks(input logic [2:0] st, input logic [2:0] bev);
        logic [3:0] n;
        n = 4'd0;
        case (st)
            HEAT:   n = HEAT_LEN;
            COFFEE: n = (bev >= BEV_ESPRESSO && bev <= BEV_MOCHA) ? 4'd4 : 4'd0;
            WATER:  n = (bev == BEV_AMERICANO) ? 4'd6 : 4'd0;
            MILK:   n = (bev == BEV_LATTE) ? 4'd6 : ((bev == BEV_MOCHA) ? 4'd4 : 4'd0);
            CHOC:   n = (bev == BEV_MOCHA) ? 4'd2 : 4'd0;
            default: n = 4'd0;
        endcase
        return n;
    endfunction

    // First stage after st that has a nonzero length; zero-length stages cost no cycles.
    function automatic logic [2:0] next_stage(input logic [2:0] st, input logic [2:0] bev);
        logic [2:0] cand;
        cand = st + 3'd1;
        for (int i = 0; i < 4; i++) begin
            if (cand != DONE && stage_ticks(cand, bev) == 4'd0) begin
                cand = cand + 3'd1;
            end
        end
        return cand;
    endfunction

    assign bev_valid    = (c_type >= BEV_ESPRESSO) && (c_type <= BEV_MOCHA);
    assign stage_active = (state >= HEAT) && (state <= CHOC);
    assign cur_ticks    = stage_ticks(state, bev_q);
    assign stage_end    = stage_active && (presc == PRESC_LAST) && (tick == cur_ticks - 4'd1);

    // Next-state selection; cancel outranks stage completion in active stages.
    always_comb begin
        state_nxt = state;
        bev_nxt   = bev_q;
        abort_now = 1'b0;
        err_now   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (bev_valid) begin
                        state_nxt = HEAT;
                        bev_nxt   = c_type;
                    end else begin
                        err_now = 1'b1;
                    end
                end
            end
            HEAT, COFFEE, WATER, MILK, CHOC: begin
                if (cancel) begin
                    state_nxt = IDLE;
                    abort_now = 1'b1;
                end else if (stage_end) begin
                    state_nxt = next_stage(state, bev_q);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State and latched beverage code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            bev_q <= 3'd0;
        end else begin
            state <= state_nxt;
            bev_q <= bev_nxt;
        end
    end

    // Prescaler and tick counter; both restart whenever the stage changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            tick  <= 4'd0;
        end else if (state_nxt != state) begin
            presc <= '0;
            tick  <= 4'd0;
        end else if (stage_active) begin
            if (presc == PRESC_LAST) begin
                presc <= '0;
                tick  <= tick + 4'd1;
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    // Registered actuator and status outputs, decoded from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            heater   <= 1'b0;
            v_coffee <= 1'b0;
            v_water  <= 1'b0;
            v_milk   <= 1'b0;
            v_choc   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
            err      <= 1'b0;
        end else begin
            heater   <= (state_nxt == HEAT);
            v_coffee <= (state_nxt == COFFEE);
            v_water  <= (state_nxt == WATER);
            v_milk   <= (state_nxt == MILK);
            v_choc   <= (state_nxt == CHOC);
            busy     <= (state_nxt != IDLE);
            done     <= (state_nxt == DONE);
            aborted  <= abort_now;
            err      <= err_now;
        end
    end

endmodule

// File: tb/tb_brew_sequencer.sv
// tb/tb_brew_sequencer.sv - scoreboard bench for brew_sequencer
module tb_brew_sequencer;

    localparam int TC = 4;
    localparam int HT = 2;

    logic       clk;
    logic       rst_n;
    logic [2:0] c_type;
    logic       start;
    logic       cancel;
    logic       heater, v_coffee, v_water, v_milk, v_choc;
    logic       busy, done, aborted, err;
    logic [8:0] obs;

    int total;
    int bad;
    logic [8:0] sb_q[$];

    brew_sequencer #(.TICK_CYC(TC), .HEAT_TICKS(HT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .c_type   (c_type),
        .start    (start),
        .cancel   (cancel),
        .heater   (heater),
        .v_coffee (v_coffee),
        .v_water  (v_water),
        .v_milk   (v_milk),
        .v_choc   (v_choc),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted),
        .err      (err)
    );

    assign obs = {heater, v_coffee, v_water, v_milk, v_choc, busy, done, aborted, err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [8:0] got, input logic [8:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got h/co/wa/mi/ch/busy/done/ab/err=%b want=%b", tag, got, want);
        end
    endtask

    // Recipe ticks for stage s (0 heat, 1 coffee, 2 water, 3 milk, 4 choc).
    function automatic int recipe(input int bev, input int s);
        case (s)
            0: return HT;
            1: return 4;
            2: return (bev == 2) ? 6 : 0;
            3: return (bev == 3) ? 6 : ((bev == 4) ? 4 : 0);
            4: return (bev == 4) ? 2 : 0;
            default: return 0;
        endcase
    endfunction

    // Expected outputs in cycle c of a brew whose start is sampled at edge 0.
    // Cancel is held high over input cycles clo..chi (clo < 0 means never).
    function automatic logic [8:0] model(input int bev, input int c, input int clo, input int chi);
        logic [8:0] v;
        int d[5];
        int tot;
        int ec;
        int acc;
        v = '0;
        if (bev < 1 || bev > 4) begin
            if (c == 1) v[0] = 1'b1;
            return v;
        end
        tot = 0;
        for (int i = 0; i < 5; i++) begin
            d[i] = recipe(bev, i) * TC;
            tot += d[i];
        end
        ec = 0;
        if (clo >= 0) begin
            ec = (clo < 1) ? 1 : clo;
            if (ec > chi || ec > tot) ec = 0;
        end
        if (ec != 0 && c > ec) begin
            if (c == ec + 1) v[1] = 1'b1;
            return v;
        end
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            if (c > acc && c <= acc + d[i]) v[8 - i] = 1'b1;
            acc += d[i];
        end
        if (c >= 1 && c <= tot + 1) v[3] = 1'b1;
        if (c == tot + 1) v[2] = 1'b1;
        return v;
    endfunction

    task automatic run_brew(input string name, input int bev, input int len, input int clo,
                            input int chi, input int chg_at, input int chg_val, input int restart_at);
        logic [8:0] want;
        for (int cyc = 0; cyc < len; cyc++) begin
            start = (cyc == 0) || (cyc == restart_at);
            if (cyc == 0) c_type = 3'(bev);
            else if (cyc == chg_at) c_type = 3'(chg_val);
            cancel = (clo >= 0) && (cyc >= clo) && (cyc <= chi);
            sb_q.push_back(model(bev, cyc + 1, clo, chi));
            @(posedge clk);
            #1;
            want = sb_q.pop_front();
            check_val($sformatf("%s c%0d", name, cyc + 1), obs, want);
        end
        start  = 1'b0;
        cancel = 1'b0;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        c_type = 3'd0;
        start  = 1'b0;
        cancel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset", obs, 9'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_brew("espresso",  1, 26, -1, -1, -1, 0, -1);
        run_brew("b2b_esp",   1, 27, -1, -1, -1, 0, -1);
        run_brew("americano", 2, 52, -1, -1, -1, 0, -1);
        run_brew("mocha_chg", 4, 52, -1, -1, 10, 2, -1);
        run_brew("latte_cxl", 3, 20, 12, 12, -1, 0, -1);
        run_brew("after_cxl", 1, 27, -1, -1, -1, 0, -1);
        run_brew("inv0",      0, 3,  -1, -1, -1, 0, -1);
        run_brew("inv6",      6, 3,  -1, -1, -1, 0, -1);
        run_brew("esp_restart", 1, 27, -1, -1, 2, 2, 2);
        run_brew("start_cxl", 3, 6,  0,  1,  -1, 0, -1);

        run_brew("amer_rst",  2, 30, -1, -1, -1, 0, -1);
        rst_n = 1'b0;
        #2;
        check_val("rst_async", obs, 9'd0);
        @(posedge clk);
        #1;
        check_val("rst_hold", obs, 9'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("rst_idle", obs, 9'd0);
        run_brew("esp_post_rst", 1, 27, -1, -1, -1, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/brew_sequencer.md
# brew_sequencer

Sequences one beverage cycle of the coffee maker: latches the 3-bit beverage code produced by the switch selector on a start request, then drives the heater and the coffee, water, milk and chocolate valves through a fixed per-beverage recipe, one stage at a time. It sits between the beverage selector and the actuator drivers. It owns all actuator timing and reports busy, done, abort and invalid-selection status to the panel logic.

## Interface
- TICK_CYC, 50_000_000: clock cycles per recipe time unit (1 s at 50 MHz); must be ≥ 2.
- HEAT_TICKS, 3: preheat duration in ticks; 1..15.
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- c_type  in  3  beverage code: 0 none, 1 espresso, 2 americano, 3 latte, 4 mocha, 5-7 invalid.
- start  in  1  request a brew; sampled only in IDLE.
- cancel  in  1  abort the current brew; level, sampled every cycle.
- heater  out  1  heater enable.
- v_coffee, v_water, v_milk, v_choc  out  1 each  valve enables.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on successful completion.
- aborted  out  1  one-cycle pulse when a brew is cancelled.
- err  out  1  one-cycle pulse when start is seen with c_type 0 or 5-7.

## Operation
- States: IDLE, HEAT, COFFEE, WATER, MILK, CHOC, DONE.
- Recipe in ticks (coffee/water/milk/choc):
  - espresso: 4/0/0/0
  - americano: 4/6/0/0
  - latte: 4/0/6/0
  - mocha: 4/0/4/2
- IDLE + start + valid c_type: latch c_type into an internal register and go to HEAT. Later c_type changes have no effect until the next IDLE.
- IDLE + start + invalid c_type: err = 1 for one cycle and stay in IDLE.
- Stage order: HEAT → COFFEE → WATER → MILK → CHOC → DONE.
  - A stage with 0 ticks is skipped and takes no cycles.
  - The next state is chosen combinationally from the latched recipe.
- Each active stage lasts exactly ticks × TICK_CYC cycles.
  - Counters: a prescaler counting 0..TICK_CYC-1 and a 4-bit tick counter.
  - Both clear on every stage entry.
- DONE lasts one cycle with done = 1, then the block returns to IDLE.
- Actuator outputs:
  - heater = (state == HEAT), v_coffee = (state == COFFEE), and likewise for the other valves.
  - All actuator outputs are registered.
  - At most one actuator is high in any cycle.
- cancel in any state other than IDLE or DONE: on the next edge go to IDLE, drop all actuators, set aborted = 1 for one cycle, and do not assert done.
- cancel in IDLE or DONE is ignored.
- cancel has priority over stage completion in the same cycle.
- start outside IDLE is ignored, with no queuing.
- start with cancel in IDLE: start wins; cancel then acts from HEAT on the next cycle.

## Timing
- Reset values: state IDLE; counters 0; latched type 0; heater, all valves, busy, done, aborted and err all 0.
- Reset asserted mid-brew clears all outputs immediately, without waiting for a clock edge.
- If start is sampled at edge k, then heater and busy are high from cycle k+1.
- Stage boundaries are contiguous: the outgoing actuator falls on the same edge the incoming actuator rises, with no gap and no overlap.
- Latency from start to done = (HEAT_TICKS + total recipe ticks) × TICK_CYC + 1 cycles.
- busy falls on the edge after DONE, or on the edge after cancel is sampled.
- Back-to-back brews: start may be accepted in the first IDLE cycle after DONE.

## Test plan
All scenarios use TICK_CYC = 4 and HEAT_TICKS = 2; start is a one-cycle pulse sampled at cycle 0.
- Espresso (c_type 1) → heater high cycles 1-8, v_coffee 9-24, done pulse at cycle 25, busy low from 26.
- Americano (2) → v_coffee 9-24, v_water 25-48, done at 49; v_milk and v_choc never high.
- Mocha (4), with c_type changed to 2 at cycle 10 → v_coffee 9-24, v_milk 25-40, v_choc 41-48, done at 49. The c_type change has no effect.
- Latte (3) with cancel high at cycle 12 → v_coffee low from 13, aborted pulse at 13, busy low at 13, no done; a new start at cycle 20 is accepted.
- c_type 0 and c_type 6 with start → err pulse at cycle 1, busy stays 0, and all actuators stay 0. A second start at cycle 5 while espresso brews (started at 3) is ignored.
- rst_n driven low at cycle 30 of an americano brew → all outputs 0 before the next edge. After release, IDLE, and a fresh espresso completes with the nominal timing.
